// File: rtl/apogeo_fetch_pkg.sv
// Shared fetch-stage definitions: bundle geometry, counter sizing and FSM states.
`ifndef IBUFFER_SIZE
`define IBUFFER_SIZE 4
`endif

package apogeo_fetch_pkg;

  // Instructions per bundle.
  localparam int unsigned IBUF_N = `IBUFFER_SIZE;

  // Byte stride between consecutive bundles.
  localparam logic [31:0] BUNDLE_BYTES = 32'(4 * `IBUFFER_SIZE);

  // Counters must represent 0..N inclusive.
  localparam int unsigned CNT_W = $clog2(IBUF_N + 1);

  // Width of a slot index inside the bundle.
  localparam int unsigned IDX_W = (IBUF_N > 1) ? $clog2(IBUF_N) : 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Byte offset of the idx-th word of a bundle.
  function automatic logic [31:0] word_offset(input logic [CNT_W-1:0] idx);
    return 32'(idx) << 2;
  endfunction

endpackage

// File: rtl/bundle_fetcher.sv
// Instruction bundle fetcher: issues N in-order word reads starting at pc,
// assembles the responses into a bundle (oldest at the top index), holds it
// until the instruction buffer takes it, and drains stale responses after a
// redirect.
//
// state | meaning
// FETCH | issuing word reads and collecting responses for the current bundle
// FULL  | bundle complete and presented, waiting for bundle_request_i
// DRAIN | redirected; discarding responses still in flight from the old stream
module bundle_fetcher
  import apogeo_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [31:0]              branch_target_i,
  input  logic                     bundle_request_i,
  output logic [IBUF_N-1:0][31:0]  instr_bundle_o,
  output logic                     bundle_valid_o,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ready_i,
  input  logic                     mem_valid_i,
  input  logic [31:0]              mem_data_i
);

  fetch_state_t     state;
  logic [31:0]      pc;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_next;
  logic [IDX_W-1:0] slot;
  logic             issue_fire;
  logic             resp_take;

  // Request generation and outstanding-count bookkeeping.
  always_comb begin
    mem_req_o  = !rst_i && (state == FETCH) && (issued_cnt < CNT_W'(IBUF_N));
    mem_addr_o = pc + word_offset(issued_cnt);
    issue_fire = mem_req_o && mem_ready_i;
    // A response with nothing outstanding cannot be ours; never underflow.
    resp_take  = mem_valid_i && (out_cnt != '0);
    out_next   = out_cnt + CNT_W'(issue_fire) - CNT_W'(resp_take);
    slot       = IDX_W'(IBUF_N - 1) - IDX_W'(recv_cnt);
  end

  // Fetch FSM with registered bundle, valid flag and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= FETCH;
      pc             <= RESET_VECTOR;
      issued_cnt     <= '0;
      recv_cnt       <= '0;
      out_cnt        <= '0;
      bundle_valid_o <= 1'b0;
      instr_bundle_o <= '0;
    end else begin
      out_cnt <= out_next;
      case (state)
        FETCH: begin
          if (flush_i) begin
            pc             <= branch_target_i;
            issued_cnt     <= '0;
            recv_cnt       <= '0;
            bundle_valid_o <= 1'b0;
            state          <= (out_next != '0) ? DRAIN : FETCH;
          end else begin
            if (issue_fire) begin
              issued_cnt <= issued_cnt + 1'b1;
            end
            if (resp_take) begin
              instr_bundle_o[slot] <= mem_data_i;
              recv_cnt             <= recv_cnt + 1'b1;
              if (recv_cnt == CNT_W'(IBUF_N - 1)) begin
                state          <= FULL;
                bundle_valid_o <= 1'b1;
              end
            end
          end
        end
        FULL: begin
          // Redirect wins over a simultaneous accept.
          if (flush_i) begin
            pc             <= branch_target_i;
            issued_cnt     <= '0;
            recv_cnt       <= '0;
            bundle_valid_o <= 1'b0;
            state          <= (out_next != '0) ? DRAIN : FETCH;
          end else if (bundle_valid_o && bundle_request_i) begin
            pc             <= pc + BUNDLE_BYTES;
            issued_cnt     <= '0;
            recv_cnt       <= '0;
            bundle_valid_o <= 1'b0;
            state          <= FETCH;
          end
        end
        DRAIN: begin
          // A further redirect only retargets; old responses still drain.
          if (flush_i) begin
            pc <= branch_target_i;
          end
          if (out_next == '0) begin
            state <= FETCH;
          end
        end
        default: begin
          state          <= FETCH;
          issued_cnt     <= '0;
          recv_cnt       <= '0;
          bundle_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bundle_fetcher.sv
// Bench for bundle_fetcher: in-order memory model with random ready/latency,
// directed redirect/reset scenarios and a randomized sequential-fetch phase.
module tb_bundle_fetcher;
  import apogeo_fetch_pkg::*;

  localparam int N = IBUF_N;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                flush_i;
  logic [31:0]         branch_target_i;
  logic                bundle_request_i;
  logic [N-1:0][31:0]  instr_bundle_o;
  logic                bundle_valid_o;
  logic                mem_req_o;
  logic [31:0]         mem_addr_o;
  logic                mem_ready_i;
  logic                mem_valid_i;
  logic [31:0]         mem_data_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bundle_fetcher #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .branch_target_i  (branch_target_i),
    .bundle_request_i (bundle_request_i),
    .instr_bundle_o   (instr_bundle_o),
    .bundle_valid_o   (bundle_valid_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ready_i      (mem_ready_i),
    .mem_valid_i      (mem_valid_i),
    .mem_data_i       (mem_data_i)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0F0F) * 32'h9E37_79B1) + 32'd7;
  endfunction

  // Expected bundle for a given base: word at base+4k lands in slot N-1-k.
  function automatic logic [N-1:0][31:0] exp_bundle(input logic [31:0] base);
    logic [N-1:0][31:0] b;
    for (int k = 0; k < N; k++) b[N-1-k] = mem_word(base + 32'(4 * k));
    return b;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  int          pend_log[$];
  int          mem_cyc = 0;
  int          rdy_pct = 100;
  int          dmin = 0;
  int          dmax = 0;
  bit          hold_ready = 1'b0;

  initial begin
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
    forever begin
      @(negedge clk_i);
      #1;
      mem_cyc++;
      mem_ready_i = !hold_ready && ($urandom_range(99) < rdy_pct);
      if (pend_q.size() > 0 && pend_q[0].rdy <= mem_cyc) begin
        mem_valid_i = 1'b1;
        mem_data_i  = mem_word(pend_q[0].addr);
      end else begin
        mem_valid_i = 1'b0;
        mem_data_i  = $urandom;
      end
      #1;
      if (rst_i) begin
        pend_q.delete();
        mem_valid_i = 1'b0;
      end else begin
        if (mem_valid_i) void'(pend_q.pop_front());
        if (mem_req_o && mem_ready_i) begin
          req_log.push_back(mem_addr_o);
          pend_log.push_back(pend_q.size());
          pend_q.push_back('{addr: mem_addr_o, rdy: mem_cyc + 1 + int'($urandom_range(dmax, dmin))});
        end
      end
    end
  end

  // ---------------- sequential-fetch monitor (random phase) ----------------
  bit                 mon_en = 1'b0;
  logic [31:0]        exp_addr;
  logic [31:0]        exp_base;
  logic [N-1:0][31:0] held;
  bit                 held_v = 1'b0;
  int                 n_bundles = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      #3;
      if (mon_en) begin
        if (held_v) begin
          check_eq("hold_bundle", instr_bundle_o, held);
          check_eq("hold_valid", bundle_valid_o, 1);
        end
        held_v = 1'b0;
        if (mem_req_o && mem_ready_i) begin
          check_eq("seq_addr", mem_addr_o, exp_addr);
          exp_addr += 32'd4;
        end
        if (bundle_valid_o) begin
          check_eq("req_in_full", mem_req_o, 0);
          if (bundle_request_i) begin
            check_eq("rand_bundle", instr_bundle_o, exp_bundle(exp_base));
            exp_base += 32'(4 * N);
            n_bundles++;
          end else begin
            held   = instr_bundle_o;
            held_v = 1'b1;
          end
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic wait_valid(input int maxc, output int cyc_n);
    cyc_n = 0;
    while (!bundle_valid_o && cyc_n < maxc) begin
      @(negedge clk_i);
      #3;
      cyc_n++;
    end
    if (!bundle_valid_o) check_eq("valid_timeout", 0, 1);
  endtask

  task automatic check_log(input string tag, input int lb, input logic [31:0] base);
    check_eq({tag, "_len"}, req_log.size(), lb + N);
    for (int k = 0; k < N; k++) begin
      if (lb + k < req_log.size()) check_eq({tag, "_addr"}, req_log[lb+k], base + 32'(4 * k));
    end
    if (lb < pend_log.size()) check_eq({tag, "_no_stale"}, pend_log[lb], 0);
  endtask

  task automatic pulse_accept();
    @(negedge clk_i);
    bundle_request_i = 1'b1;
    @(negedge clk_i);
    bundle_request_i = 1'b0;
    #3;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N-1:0][31:0] saved;
    int vc;
    int lb;
    rst_i            = 1'b1;
    flush_i          = 1'b0;
    bundle_request_i = 1'b0;
    branch_target_i  = '0;

    repeat (3) @(negedge clk_i);
    #3;
    check_eq("rst_req", mem_req_o, 0);
    check_eq("rst_valid", bundle_valid_o, 0);
    check_eq("rst_bundle", instr_bundle_o, 0);

    // Reset release, ready always, 1-cycle latency.
    @(negedge clk_i);
    rst_i = 1'b0;
    req_log.delete();
    pend_log.delete();
    #3;
    check_eq("first_req", mem_req_o, 1);
    check_eq("first_addr", mem_addr_o, 32'h0);
    wait_valid(20, vc);
    check_eq("valid_cycle", vc, 5);
    check_log("t1", 0, 32'h0);
    check_eq("t1_bundle", instr_bundle_o, exp_bundle(32'h0));
    check_eq("t1_top_word", instr_bundle_o[N-1], mem_word(32'h0));

    // Hold with no request for 10 cycles.
    saved = instr_bundle_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #3;
      check_eq("hold_bundle_d", instr_bundle_o, saved);
      check_eq("hold_valid_d", bundle_valid_o, 1);
      check_eq("hold_noreq_d", mem_req_o, 0);
    end
    pulse_accept();
    check_eq("acc_valid_low", bundle_valid_o, 0);
    check_eq("acc_req", mem_req_o, 1);
    check_eq("acc_addr", mem_addr_o, 32'h10);
    wait_valid(20, vc);
    check_eq("t2_bundle", instr_bundle_o, exp_bundle(32'h10));

    // Flush after 2 issued, none returned.
    dmin = 6;
    dmax = 6;
    pulse_accept();
    @(negedge clk_i);
    @(negedge clk_i);
    hold_ready      = 1'b1;
    flush_i         = 1'b1;
    branch_target_i = 32'h200;
    #3;
    check_eq("t3_outstanding", pend_q.size(), 2);
    lb = req_log.size();
    @(negedge clk_i);
    flush_i    = 1'b0;
    hold_ready = 1'b0;
    dmin       = 0;
    dmax       = 0;
    #3;
    check_eq("t3_drain_noreq", mem_req_o, 0);
    wait_valid(40, vc);
    check_log("t3", lb, 32'h200);
    check_eq("t3_bundle", instr_bundle_o, exp_bundle(32'h200));

    // Flush and accept together.
    @(negedge clk_i);
    flush_i          = 1'b1;
    bundle_request_i = 1'b1;
    branch_target_i  = 32'h80;
    @(negedge clk_i);
    flush_i          = 1'b0;
    bundle_request_i = 1'b0;
    #3;
    check_eq("t4_valid_low", bundle_valid_o, 0);
    check_eq("t4_req", mem_req_o, 1);
    check_eq("t4_addr", mem_addr_o, 32'h80);
    wait_valid(20, vc);
    check_eq("t4_bundle", instr_bundle_o, exp_bundle(32'h80));

    // Wrap past the top of the address space.
    @(negedge clk_i);
    flush_i         = 1'b1;
    branch_target_i = 32'hFFFF_FFF0;
    @(negedge clk_i);
    flush_i = 1'b0;
    #3;
    wait_valid(20, vc);
    check_eq("t5_bundle", instr_bundle_o, exp_bundle(32'hFFFF_FFF0));
    pulse_accept();
    check_eq("t5_wrap_req", mem_req_o, 1);
    check_eq("t5_wrap_addr", mem_addr_o, 32'h0);
    wait_valid(20, vc);

    // Flush while a request issues, then a second flush during drain.
    dmin = 8;
    dmax = 8;
    @(negedge clk_i);
    flush_i         = 1'b1;
    branch_target_i = 32'h300;
    @(negedge clk_i);
    flush_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    flush_i         = 1'b1;
    branch_target_i = 32'h400;
    @(negedge clk_i);
    branch_target_i = 32'h500;
    #3;
    check_eq("t6_outstanding", pend_q.size(), 3);
    lb = req_log.size();
    @(negedge clk_i);
    flush_i = 1'b0;
    dmin    = 0;
    dmax    = 0;
    #3;
    wait_valid(40, vc);
    check_log("t6", lb, 32'h500);
    check_eq("t6_bundle", instr_bundle_o, exp_bundle(32'h500));

    // Reset with reads in flight.
    dmin = 4;
    dmax = 4;
    pulse_accept();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #3;
    check_eq("t7_rst_req", mem_req_o, 0);
    check_eq("t7_rst_valid", bundle_valid_o, 0);
    check_eq("t7_rst_bundle", instr_bundle_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    dmin  = 0;
    dmax  = 0;
    lb    = req_log.size();
    #3;
    check_eq("t7_req", mem_req_o, 1);
    check_eq("t7_addr", mem_addr_o, 32'h0);
    wait_valid(20, vc);
    check_log("t7", lb, 32'h0);
    check_eq("t7_bundle", instr_bundle_o, exp_bundle(32'h0));

    // Random ready, random latency, random request.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rdy_pct  = 50;
    dmin     = 0;
    dmax     = 3;
    exp_addr = 32'h0;
    exp_base = 32'h0;
    rst_i    = 1'b0;
    mon_en   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bundle_request_i = ($urandom_range(99) < 30);
      @(negedge clk_i);
    end
    bundle_request_i = 1'b0;
    mon_en           = 1'b0;
    check_eq("rand_progress", (n_bundles > 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
